sram_arbiter: RTL

SRAM_ARBITER -- requirements
Module: sram_arbiter

---
 rtl/sram_arbiter.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/sram_arbiter.sv
// Two-port (fetch / data) arbiter onto a single asynchronous 32-bit SRAM.
// Define SRAM_ARB_RR_EN for round-robin grants; otherwise the data port always wins.
module sram_arbiter #(
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ready,
  output logic        if_wait,
  input  logic        mem_req,
  input  logic        mem_wr,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_be,
  output logic [31:0] mem_rdata,
  output logic        mem_ready,
  output logic        mem_wait,
  output logic [17:0] sram_addr,
  output logic [31:0] sram_dout,
  input  logic [31:0] sram_din,
  output logic        sram_doe,
  output logic        sram_ce_n,
  output logic        sram_oe_n,
  output logic        sram_we_n,
  output logic [3:0]  sram_be_n
);

  typedef enum logic [2:0] {
    StIdle, StRd, StRdDone, StWrSetup, StWr, StWrDone
  } state_e;

  localparam logic [3:0] WaitLast = 4'(WAIT_CYCLES);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        owner_q, owner_d;  // 1 = data port owns the current access
  logic [17:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] if_rdata_q, mem_rdata_q;
  logic        grant_mem;
  logic        rd_last;
  logic        unused_addr;

  assign unused_addr = ^{if_addr[31:20], if_addr[1:0], mem_addr[31:20], mem_addr[1:0]};

`ifdef SRAM_ARB_RR_EN
  logic last_mem_q;

  assign grant_mem = mem_req & (~if_req | ~last_mem_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_mem_q <= 1'b0;
    end else if (state_q == StIdle && (if_req || mem_req)) begin
      last_mem_q <= grant_mem;
    end
  end
`else
  assign grant_mem = mem_req;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    owner_d = owner_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    rd_last = 1'b0;
    unique case (state_q)
      StIdle: begin
        cnt_d = 4'd0;
        if (if_req || mem_req) begin
          owner_d = grant_mem;
          addr_d  = grant_mem ? mem_addr[19:2] : if_addr[19:2];
          wdata_d = mem_wdata;
          be_d    = mem_be;
          state_d = (grant_mem && mem_wr) ? StWrSetup : StRd;
        end
      end
      StRd: begin
        if (cnt_q == WaitLast) begin
          rd_last = 1'b1;
          cnt_d   = 4'd0;
          state_d = StRdDone;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      StRdDone:  state_d = StIdle;
      StWrSetup: state_d = StWr;
      StWr: begin
        if (cnt_q == WaitLast) begin
          cnt_d   = 4'd0;
          state_d = StWrDone;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      StWrDone:  state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      owner_q <= 1'b0;
      addr_q  <= 18'd0;
      wdata_q <= 32'd0;
      be_q    <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      owner_q <= owner_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      if_rdata_q  <= 32'd0;
      mem_rdata_q <= 32'd0;
    end else if (rd_last) begin
      if (owner_q) mem_rdata_q <= sram_din;
      else         if_rdata_q  <= sram_din;
    end
  end

  // Strobes decode straight from state so an async reset releases the bus at once.
  always_comb begin
    sram_ce_n = 1'b1;
    sram_oe_n = 1'b1;
    sram_we_n = 1'b1;
    sram_be_n = 4'b1111;
    sram_doe  = 1'b0;
    unique case (state_q)
      StRd: begin
        sram_ce_n = 1'b0;
        sram_oe_n = 1'b0;
        sram_be_n = 4'b0000;
      end
      StWrSetup, StWrDone: begin
        sram_ce_n = 1'b0;
        sram_doe  = 1'b1;
        sram_be_n = ~be_q;
      end
      StWr: begin
        sram_ce_n = 1'b0;
        sram_we_n = 1'b0;
        sram_doe  = 1'b1;
        sram_be_n = ~be_q;
      end
      default: ;
    endcase
  end

  assign if_ready  = (state_q == StRdDone) && !owner_q;
  assign mem_ready = ((state_q == StRdDone) && owner_q) || (state_q == StWrDone);
  assign if_wait   = if_req & ~if_ready;
  assign mem_wait  = mem_req & ~mem_ready;
  assign if_rdata  = if_rdata_q;
  assign mem_rdata = mem_rdata_q;
  assign sram_addr = addr_q;
  assign sram_dout = wdata_q;

endmodule
